// File: rtl/ahb_bm_pkg.sv
// Shared bus-matrix definitions: AHB transfer/burst encodings and the
// port codes used on the addr_in_port/no_port output-stage contract.
package ahb_bm_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'b000,
    HBURST_INCR   = 3'b001,
    HBURST_WRAP4  = 3'b010,
    HBURST_INCR4  = 3'b011,
    HBURST_WRAP8  = 3'b100,
    HBURST_INCR8  = 3'b101,
    HBURST_WRAP16 = 3'b110,
    HBURST_INCR16 = 3'b111
  } hburst_e;

  localparam logic [1:0] PORT_NONE = 2'b00;
  localparam logic [1:0] PORT1     = 2'b01;
  localparam logic [1:0] PORT2     = 2'b10;
  localparam logic [1:0] PORT3     = 2'b11;

  // Round-robin successor of a port code, wrapping 3 back to 1.
  function automatic logic [1:0] port_next(input logic [1:0] p);
    return (p == PORT3) ? PORT1 : p + 2'd1;
  endfunction

endpackage

// File: rtl/ahb_burst_tracker.sv
// Tracks the remaining beats of a fixed-length burst on the muxed slave
// interface; next_hold_o tells the arbiter the burst is still in progress.
module ahb_burst_tracker
  import ahb_bm_pkg::*;
(
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic       hready_i,
  input  logic       hsel_i,
  input  logic [1:0] htrans_i,
  input  logic [2:0] hburst_i,
  output logic       next_hold_o
);

  logic [3:0] remain_q, remain_d;
  logic       hold_q, hold_d;

  // NOTE: every variable assigned here gets a default first, so no path
  // through the case statements can leave it unassigned and infer a latch.
  always_comb begin
    remain_d = remain_q;
    hold_d   = hold_q;
    if (!hsel_i || htrans_i == HTRANS_IDLE) begin
      remain_d = '0;
      hold_d   = 1'b0;
    end else begin
      case (htrans_i)
        HTRANS_NONSEQ: begin
          case (hburst_i)
            HBURST_WRAP4,  HBURST_INCR4:  begin remain_d = 4'd3;  hold_d = 1'b1; end
            HBURST_WRAP8,  HBURST_INCR8:  begin remain_d = 4'd7;  hold_d = 1'b1; end
            HBURST_WRAP16, HBURST_INCR16: begin remain_d = 4'd15; hold_d = 1'b1; end
            default:                      begin remain_d = '0;    hold_d = 1'b0; end
          endcase
        end
        HTRANS_SEQ: begin
          if (remain_q == '0) begin
            remain_d = '0;
            hold_d   = 1'b0;
          end else begin
            remain_d = remain_q - 4'd1;
            hold_d   = (remain_q != 4'd1);
          end
        end
        default: ; // BUSY: the burst is paused, nothing moves
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      remain_q <= '0;
      hold_q   <= 1'b0;
    end else if (hready_i) begin
      remain_q <= remain_d;
      hold_q   <= hold_d;
    end
  end

  assign next_hold_o = hold_d;

endmodule

// File: rtl/ahb_wrr_output_arbiter.sv
// Weighted round-robin output-stage arbiter for one slave port with three
// input stages; grants persist across locks and fixed bursts.
module ahb_wrr_output_arbiter
  import ahb_bm_pkg::*;
#(
  parameter int WEIGHT1 = 4,
  parameter int WEIGHT2 = 4,
  parameter int WEIGHT3 = 4,
  parameter int CNT_W   = 4
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             req_port1,
  input  logic             req_port2,
  input  logic             req_port3,
  input  logic             HREADYM,
  input  logic             HSELM,
  input  logic [1:0]       HTRANSM,
  input  logic [2:0]       HBURSTM,
  input  logic             HMASTLOCKM,
  output logic [1:0]       addr_in_port,
  output logic             no_port,
  output logic [CNT_W-1:0] credit_left
);

  // A zero weight would starve a port, so it is promoted to one credit.
  localparam logic [CNT_W-1:0] W1 = (WEIGHT1 == 0) ? CNT_W'(1) : CNT_W'(WEIGHT1);
  localparam logic [CNT_W-1:0] W2 = (WEIGHT2 == 0) ? CNT_W'(1) : CNT_W'(WEIGHT2);
  localparam logic [CNT_W-1:0] W3 = (WEIGHT3 == 0) ? CNT_W'(1) : CNT_W'(WEIGHT3);

  function automatic logic [CNT_W-1:0] weight_of(input logic [1:0] p);
    case (p)
      PORT1:   return W1;
      PORT2:   return W2;
      PORT3:   return W3;
      default: return '0;
    endcase
  endfunction

  logic [1:0]       addr_q, addr_d;
  logic             no_port_q, no_port_d;
  logic [CNT_W-1:0] credit_q, credit_d;

  logic             next_hold;
  logic             xfer;
  logic [CNT_W-1:0] credit_dec;
  logic [3:0]       req_vec;
  logic [1:0]       cand1, cand2;

  ahb_burst_tracker u_burst_tracker (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .hready_i    (HREADYM),
    .hsel_i      (HSELM),
    .htrans_i    (HTRANSM),
    .hburst_i    (HBURSTM),
    .next_hold_o (next_hold)
  );

  assign xfer       = HSELM & HTRANSM[1];
  assign credit_dec = (xfer && credit_q != '0) ? credit_q - CNT_W'(1) : credit_q;
  assign req_vec    = {req_port3, req_port2, req_port1, 1'b0};
  assign cand1      = port_next(addr_q);
  assign cand2      = port_next(cand1);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_q    <= PORT_NONE;
      no_port_q <= 1'b1;
      credit_q  <= '0;
    end else if (HREADYM) begin
      addr_q    <= addr_d;
      no_port_q <= no_port_d;
      credit_q  <= credit_d;
    end
  end

  // Decision ladder: lock/burst, idle pick, keep, rotate, reload, release.
  always_comb begin
    addr_d    = addr_q;
    no_port_d = no_port_q;
    credit_d  = credit_q;
    if (HMASTLOCKM || next_hold) begin
      credit_d = credit_dec;
    end else if (no_port_q) begin
      if (req_port1) begin
        addr_d = PORT1; no_port_d = 1'b0; credit_d = W1;
      end else if (req_port2) begin
        addr_d = PORT2; no_port_d = 1'b0; credit_d = W2;
      end else if (req_port3) begin
        addr_d = PORT3; no_port_d = 1'b0; credit_d = W3;
      end
    end else if (req_vec[addr_q] && credit_dec != '0) begin
      credit_d = credit_dec;
    end else if (req_vec[cand1]) begin
      addr_d = cand1; credit_d = weight_of(cand1);
    end else if (req_vec[cand2]) begin
      addr_d = cand2; credit_d = weight_of(cand2);
    end else if (HSELM) begin
      credit_d = weight_of(addr_q);
    end else begin
      no_port_d = 1'b1;
      credit_d  = '0;
    end
  end

  always_comb begin
    no_port      = no_port_q;
    credit_left  = credit_q;
    addr_in_port = (!no_port_q && addr_q == PORT_NONE) ? 2'bxx : addr_q;
  end

  a_grant_has_port : assert property (@(posedge HCLK) disable iff (!HRESETn)
    !(!no_port_q && addr_q == PORT_NONE))
    else $error("grant active with no port code");

endmodule

// File: tb/tb_ahb_wrr_output_arbiter.sv
// Scoreboard bench for the weighted round-robin output arbiter
// (WEIGHT1=2, WEIGHT2=4, WEIGHT3=4).
module tb_ahb_wrr_output_arbiter;
  import ahb_bm_pkg::*;

  typedef struct packed {
    logic [1:0] addr;
    logic       np;
    logic [3:0] cred;
  } exp_t;

  logic       HCLK = 1'b0;
  logic       HRESETn;
  logic       req_port1, req_port2, req_port3;
  logic       HREADYM, HSELM, HMASTLOCKM;
  logic [1:0] HTRANSM;
  logic [2:0] HBURSTM;
  logic [1:0] addr_in_port;
  logic       no_port;
  logic [3:0] credit_left;

  exp_t  sb_q[$];
  string tag_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  ahb_wrr_output_arbiter #(
    .WEIGHT1(2), .WEIGHT2(4), .WEIGHT3(4), .CNT_W(4)
  ) dut (
    .HCLK         (HCLK),
    .HRESETn      (HRESETn),
    .req_port1    (req_port1),
    .req_port2    (req_port2),
    .req_port3    (req_port3),
    .HREADYM      (HREADYM),
    .HSELM        (HSELM),
    .HTRANSM      (HTRANSM),
    .HBURSTM      (HBURSTM),
    .HMASTLOCKM   (HMASTLOCKM),
    .addr_in_port (addr_in_port),
    .no_port      (no_port),
    .credit_left  (credit_left)
  );

  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, queue the expected post-edge outputs, then
  // pop and compare them #1 after the edge.
  task automatic step(input string tag, input logic [2:0] req, input logic rdy,
                      input logic sel, input logic [1:0] trans, input logic [2:0] burst,
                      input logic lock, input logic [1:0] e_addr, input logic e_np,
                      input logic [3:0] e_cred);
    exp_t  e;
    string t;
    {req_port3, req_port2, req_port1} = req;
    HREADYM    = rdy;
    HSELM      = sel;
    HTRANSM    = trans;
    HBURSTM    = burst;
    HMASTLOCKM = lock;
    e.addr = e_addr;
    e.np   = e_np;
    e.cred = e_cred;
    sb_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge HCLK);
    #1;
    e = sb_q.pop_front();
    t = tag_q.pop_front();
    check({t, ".addr"}, 32'(addr_in_port), 32'(e.addr));
    check({t, ".no_port"}, 32'(no_port), 32'(e.np));
    check({t, ".credit"}, 32'(credit_left), 32'(e.cred));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    HRESETn = 1'b0;
    {req_port3, req_port2, req_port1} = 3'b000;
    HREADYM = 1'b1; HSELM = 1'b0; HTRANSM = HTRANS_IDLE;
    HBURSTM = HBURST_SINGLE; HMASTLOCKM = 1'b0;
    repeat (2) @(posedge HCLK);
    #1;
    check("reset.addr", 32'(addr_in_port), 32'd0);
    check("reset.no_port", 32'(no_port), 32'd1);
    check("reset.credit", 32'(credit_left), 32'd0);
    HRESETn = 1'b1;

    // Idle pick: port 2 beats port 3 under fixed priority.
    step("grant_p2", 3'b110, 1, 0, HTRANS_IDLE, HBURST_SINGLE, 0, 2'b10, 0, 4'd4);
    for (int i = 0; i < 3; i++)
      step("p2_credit", 3'b110, 1, 1, HTRANS_NONSEQ, HBURST_SINGLE, 0, 2'b10, 0, 4'(3 - i));
    step("p2_rotate", 3'b110, 1, 1, HTRANS_NONSEQ, HBURST_SINGLE, 0, 2'b11, 0, 4'd4);

    // Rotation from 3 wraps to 1; then an INCR8 overruns port 1's budget.
    step("rot_p1", 3'b001, 1, 0, HTRANS_IDLE, HBURST_SINGLE, 0, 2'b01, 0, 4'd2);
    step("p1_xfer", 3'b011, 1, 1, HTRANS_NONSEQ, HBURST_SINGLE, 0, 2'b01, 0, 4'd1);
    step("incr8_nseq", 3'b011, 1, 1, HTRANS_NONSEQ, HBURST_INCR8, 0, 2'b01, 0, 4'd0);
    for (int i = 0; i < 3; i++)
      step("incr8_seq", 3'b011, 1, 1, HTRANS_SEQ, HBURST_INCR8, 0, 2'b01, 0, 4'd0);
    step("incr8_busy", 3'b011, 1, 1, HTRANS_BUSY, HBURST_INCR8, 0, 2'b01, 0, 4'd0);
    for (int i = 0; i < 3; i++)
      step("incr8_seq", 3'b011, 1, 1, HTRANS_SEQ, HBURST_INCR8, 0, 2'b01, 0, 4'd0);
    step("incr8_last", 3'b011, 1, 1, HTRANS_SEQ, HBURST_INCR8, 0, 2'b10, 0, 4'd4);

    // Wait states freeze everything, whatever the inputs do.
    step("p2_xfer", 3'b010, 1, 1, HTRANS_NONSEQ, HBURST_SINGLE, 0, 2'b10, 0, 4'd3);
    for (int i = 0; i < 5; i++)
      step("stall", 3'(i + 1), 0, 1, HTRANS_NONSEQ, HBURST_INCR4, 1'(i), 2'b10, 0, 4'd3);
    step("resume", 3'b101, 1, 0, HTRANS_IDLE, HBURST_SINGLE, 0, 2'b11, 0, 4'd4);

    // Sole requester exhausts credits: new tenure, then release to no_port.
    for (int i = 0; i < 3; i++)
      step("p3_credit", 3'b100, 1, 1, HTRANS_NONSEQ, HBURST_SINGLE, 0, 2'b11, 0, 4'(3 - i));
    step("p3_reload", 3'b100, 1, 1, HTRANS_NONSEQ, HBURST_SINGLE, 0, 2'b11, 0, 4'd4);
    step("release", 3'b000, 1, 0, HTRANS_IDLE, HBURST_SINGLE, 0, 2'b11, 1, 4'd0);

    // Locked sequence overruns WEIGHT1=2; unlocking with IDLE rotates.
    step("p1_grant", 3'b001, 1, 0, HTRANS_IDLE, HBURST_SINGLE, 0, 2'b01, 0, 4'd2);
    for (int i = 0; i < 6; i++)
      step("lock_xfer", 3'b011, 1, 1, HTRANS_NONSEQ, HBURST_SINGLE, 1, 2'b01, 0,
           (i < 2) ? 4'(1 - i) : 4'd0);
    step("unlock", 3'b011, 1, 1, HTRANS_IDLE, HBURST_SINGLE, 0, 2'b10, 0, 4'd4);

    // Asynchronous reset in the middle of an INCR4 burst.
    step("p2_incr4", 3'b010, 1, 1, HTRANS_NONSEQ, HBURST_INCR4, 0, 2'b10, 0, 4'd3);
    HTRANSM = HTRANS_SEQ;
    #3;
    HRESETn = 1'b0;
    #1;
    check("async_rst.addr", 32'(addr_in_port), 32'd0);
    check("async_rst.no_port", 32'(no_port), 32'd1);
    check("async_rst.credit", 32'(credit_left), 32'd0);
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    // A SEQ right after reset must not look like a held burst.
    step("post_reset", 3'b100, 1, 1, HTRANS_SEQ, HBURST_INCR4, 0, 2'b11, 0, 4'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
